// File: rtl/rshift_pkg.sv
// Shared types and default sizing for the sequential right-shift divider.
// Optional rounding of the final quotient is enabled by defining RSHIFT_ROUND_EN.
// Holds the FSM state encoding plus default operand and shift-amount widths.
package rshift_pkg;

  // Default operand width; matches the output of the left-shift stage.
  localparam int RSH_WIDTH = 9;
  // Default shift-amount width; amounts run 0..2^SHW-1.
  localparam int RSH_SHW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/rshift1.sv
// Single-bit combinational right shift with an explicit fill bit.
// Latency: zero cycles; pure combinational logic.
// No flow control: the output follows the inputs directly.
module rshift1 #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] val,
  input  logic             fill,
  output logic [WIDTH-1:0] shifted,
  output logic             bit_out
);

  // Fill bit enters at the MSB; the LSB falls off and is reported separately.
  assign shifted = {fill, val[WIDTH-1:1]};
  assign bit_out = val[0];

endmodule

// File: rtl/rshift_div2n.sv
// Sequential divide-by-2^amt: one bit per clock, reports the quotient, top-aligned fraction bits and a sticky bit.
// Latency: amt+1 cycles from the start edge to the done pulse (1 cycle when amt=0). RSHIFT_ROUND_EN adds half-up rounding.
// Backpressure: none; start is only sampled in IDLE and is ignored (not queued) while busy.
module rshift_div2n
  import rshift_pkg::*;
#(
  parameter int WIDTH = RSH_WIDTH,
  parameter int SHW   = RSH_SHW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   amt,
  input  logic             arith,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rem,
  output logic             sticky
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             sticky_q, sticky_d;
  logic [SHW-1:0]   count_q, count_d;
  logic             mode_q, mode_d;

  logic [WIDTH-1:0] sh_val;
  logic             sh_bit;
  logic             last_shift;

  // Single datapath stage; sign-fill only in arithmetic mode.
  rshift1 #(
    .WIDTH (WIDTH)
  ) u_rshift1 (
    .val     (out_q),
    .fill    (mode_q & out_q[WIDTH-1]),
    .shifted (sh_val),
    .bit_out (sh_bit)
  );

  assign last_shift = (count_q == SHW'(1));

  // Next-state and working-register update for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    rem_d    = rem_q;
    sticky_d = sticky_q;
    count_d  = count_q;
    mode_d   = mode_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          out_d    = in;
          rem_d    = '0;
          sticky_d = 1'b0;
          count_d  = amt;
          mode_d   = arith;
          state_d  = (amt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        out_d    = sh_val;
        rem_d    = {sh_bit, rem_q[WIDTH-1:1]};
        sticky_d = sticky_q | sh_bit;
        count_d  = count_q - SHW'(1);
`ifdef RSHIFT_ROUND_EN
        // Round half up on the last edge: add back the bit leaving on that edge.
        if (last_shift) begin
          out_d = sh_val + {{(WIDTH-1){1'b0}}, sh_bit};
        end
`endif
        if (last_shift) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and working registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      out_q    <= '0;
      rem_q    <= '0;
      sticky_q <= 1'b0;
      count_q  <= '0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      rem_q    <= rem_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
      mode_q   <= mode_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign out    = out_q;
  assign rem    = rem_q;
  assign sticky = sticky_q;

endmodule

// File: tb/tb_rshift_div2n.sv
// Directed bench for rshift_div2n: vector table plus ignore-while-busy and mid-run reset sequences.
// Expected quotients switch with RSHIFT_ROUND_EN to match the rounding build.
// Each wait for done is bounded by a cycle budget.
module tb_rshift_div2n;

  localparam int W = 9;
  localparam int S = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] din;
  logic [S-1:0] amt;
  logic         arith;
  logic         busy;
  logic         done;
  logic [W-1:0] dout;
  logic [W-1:0] rem;
  logic         sticky;

  int checks = 0;
  int errors = 0;

  rshift_div2n #(.WIDTH(W), .SHW(S)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .in     (din),
    .amt    (amt),
    .arith  (arith),
    .busy   (busy),
    .done   (done),
    .out    (dout),
    .rem    (rem),
    .sticky (sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] in_v;
    logic [S-1:0] amt_v;
    logic         arith_v;
    logic [W-1:0] exp_out;
    logic [W-1:0] exp_rem;
    logic         exp_sticky;
    int           exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse start for one edge, wait for done, return observed latency (-1 on timeout).
  task automatic run_op(input logic [W-1:0] i_v, input logic [S-1:0] a_v,
                        input logic ar_v, output int lat);
    int cyc;
    @(negedge clk);
    start = 1'b1; din = i_v; amt = a_v; arith = ar_v;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    lat = done ? cyc : -1;
  endtask

  initial begin
    int lat;
    int done_cnt;

    // in, amt, arith, out, rem, sticky, latency
    vecs[0] = '{9'h0B7, 4'd2,  1'b0, 9'h02D, 9'h180, 1'b1, 3};
    vecs[1] = '{9'h1F0, 4'd3,  1'b1, 9'h1FE, 9'h000, 1'b0, 4};
    vecs[2] = '{9'h155, 4'd0,  1'b0, 9'h155, 9'h000, 1'b0, 1};
    vecs[3] = '{9'h1FF, 4'd12, 1'b0, 9'h000, 9'h03F, 1'b1, 13};
    vecs[4] = '{9'h100, 4'd12, 1'b1, 9'h1FF, 9'h1E0, 1'b1, 13};
    vecs[5] = '{9'h155, 4'd1,  1'b0, 9'h0AA, 9'h100, 1'b1, 2};
    vecs[6] = '{9'h155, 4'd1,  1'b1, 9'h1AA, 9'h100, 1'b1, 2};
    vecs[7] = '{9'h001, 4'd15, 1'b0, 9'h000, 9'h000, 1'b1, 16};
`ifdef RSHIFT_ROUND_EN
    vecs[0].exp_out = 9'h02E;
    vecs[4].exp_out = 9'h000;
    vecs[5].exp_out = 9'h0AB;
    vecs[6].exp_out = 9'h1AB;
`endif

    rst_n = 1'b0; start = 1'b0; din = '0; amt = '0; arith = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out", 32'(dout), 32'd0);
    chk("rst_rem", 32'(rem), 32'd0);
    chk("rst_sticky", 32'(sticky), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].in_v, vecs[i].amt_v, vecs[i].arith_v, lat);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_out", i), 32'(dout), 32'(vecs[i].exp_out));
      chk($sformatf("v%0d_rem", i), 32'(rem), 32'(vecs[i].exp_rem));
      chk($sformatf("v%0d_sticky", i), 32'(sticky), 32'(vecs[i].exp_sticky));
      chk($sformatf("v%0d_busy_done", i), 32'(busy), 32'd1);
      @(negedge clk);
      chk($sformatf("v%0d_idle_done", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_idle_busy", i), 32'(busy), 32'd0);
      chk($sformatf("v%0d_hold_out", i), 32'(dout), 32'(vecs[i].exp_out));
    end

    // Start asserted while busy must be ignored.
    @(negedge clk);
    start = 1'b1; din = 9'h0B7; amt = 4'd2; arith = 1'b0;
    @(negedge clk);
    din = 9'h0FF; amt = 4'd5;
    done_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      if (done) done_cnt++;
      if (done) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    chk("busy_ign_dones", 32'(done_cnt), 32'd1);
    chk("busy_ign_out", 32'(dout), 32'(vecs[0].exp_out));
    chk("busy_ign_rem", 32'(rem), 32'h180);
    chk("busy_ign_idle", 32'(busy), 32'd0);

    // Reset in the middle of a shift aborts without a done pulse.
    @(negedge clk);
    start = 1'b1; din = 9'h0B7; amt = 4'd5; arith = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mid_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_out", 32'(dout), 32'd0);
    chk("mid_rst_rem", 32'(rem), 32'd0);
    chk("mid_rst_sticky", 32'(sticky), 32'd0);
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    chk("mid_rst_no_done", 32'(done_cnt), 32'd0);
    run_op(9'h1F0, 4'd3, 1'b1, lat);
    chk("post_rst_lat", 32'(lat), 32'd4);
    chk("post_rst_out", 32'(dout), 32'h1FE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rshift_div2n.md
# rshift_div2n

Sequential divide-by-power-of-two unit for the division devices: shifts a WIDTH-bit operand right by a programmable amount, one bit per clock, under a start/busy/done handshake. It is the inverse-direction companion of the combinational left-shift stage. It returns the quotient, the shifted-out fraction bits, and a sticky bit for rounding decisions downstream.

## Interface
- WIDTH, 9, operand/result width (matches left-shift stage output)
- SHW, 4, shift-amount width; amounts 0..2^SHW-1
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- in  in  WIDTH  dividend, captured with start
- amt  in  SHW  shift amount, captured with start
- arith  in  1  1 = arithmetic (sign-fill), 0 = logical (zero-fill), captured with start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse, results valid
- out  out  WIDTH  quotient
- rem  out  WIDTH  shifted-out bits, top-aligned (last bit out at MSB)
- sticky  out  1  OR of all shifted-out bits

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: start=1 loads out<=in, rem<=0, sticky<=0, count<=amt, mode<=arith. Next state is SHIFT if amt!=0, else DONE.
- SHIFT, each edge:
  - out <= {fill, out[WIDTH-1:1]}, where fill = mode ? out[WIDTH-1] : 0
  - rem <= {out[0], rem[WIDTH-1:1]}
  - sticky <= sticky | out[0]
  - count decrements; on the edge where count reaches 0, go to DONE.
- DONE: done=1 for one cycle, then IDLE unconditionally.
- start while busy (SHIFT or DONE) is ignored; no queuing.
- amt >= WIDTH: shifting continues for all amt cycles.
  - Logical: out = 0. Arithmetic: out = all sign bits.
  - rem holds only the last WIDTH bits out; sticky covers all bits shifted out.
- out, rem and sticky are working registers. They show intermediate values while busy, final values while done=1, and hold until the next accepted start.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, out=0, rem=0, sticky=0, done=0, busy=0. This applies mid-operation too; the aborted operation never pulses done.
- Let E0 be the edge that samples start. Shifts occur at E1..E_amt, and done is high in the cycle after E_amt. Latency is amt+1 cycles (1 cycle for amt=0).
- busy rises after E0 and falls after the DONE cycle.
- Back-to-back operations: the earliest next start is sampled at the edge ending the DONE cycle +1, i.e. the first IDLE cycle.

## Configuration
- RSHIFT_ROUND_EN defined:
  - The final SHIFT edge writes out = shifted value + the bit shifted out on that edge (round half up, two's-complement add in WIDTH bits).
  - No overflow is possible for amt>=1. amt=0 is not rounded. Latency is unchanged.
- RSHIFT_ROUND_EN undefined: truncation (floor toward −∞ for arithmetic, toward 0 for logical).
- rem and sticky are identical in both builds.

## Structure
- Package rshift_pkg:
  - state enum typedef (IDLE, SHIFT, DONE)
  - default WIDTH and SHW constants
- Sub-module rshift1: combinational single-bit right shift. Inputs are the value and the fill bit; outputs are the shifted value and the bit out. It mirrors the left-shift stage. The FSM and registers stay in rshift_div2n.

## Test plan
- Logical: in=0x0B7, amt=2, arith=0.
  - done 3 cycles after start; out=0x02D, rem=0x180, sticky=1.
  - With RSHIFT_ROUND_EN: out=0x02E.
- Arithmetic: in=0x1F0, amt=3, arith=1.
  - done 4 cycles after start; out=0x1FE, rem=0x000, sticky=0.
- Zero shift: in=0x155, amt=0 → done 1 cycle after start; out=0x155, rem=0, sticky=0; busy high for exactly 1 cycle.
- Over-shift, amt=12:
  - Logical, in=0x1FF → out=0x000, sticky=1.
  - Arithmetic, in=0x100 → out=0x1FF.
- start=1 with in=0x0FF, amt=5 pulsed during an active in=0x0B7, amt=2 operation → ignored; results match the first operation; no extra done.
- rst_n=0 for one edge during SHIFT → next cycle all outputs 0, busy=0; done never asserts. A following start runs normally.
